// File: rtl/b02_line_arbiter.sv
// b02_line_arbiter: grants one of NREQ requesters, serialises its frame LSB-first onto LINEA and counts U hits.
// Arbitration is fixed priority by default; defining B02_LINE_ARB_RR_EN selects round robin.
module b02_line_arbiter #(
   parameter int NREQ  = 4,
   parameter int FLEN  = 8,
   parameter int DRAIN = 2,
   parameter int HW    = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*FLEN-1:0] frame,
   output logic [NREQ-1:0]      gnt,
   output logic                 LINEA,
   input  logic                 U,
   output logic                 done,
   output logic [3:0]           done_id,
   output logic [HW-1:0]        hits,
   output logic                 busy
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BW = $clog2(FLEN);
   localparam int DW = $clog2(DRAIN + 2);
   localparam logic [BW-1:0] LAST_BIT = BW'(FLEN - 1);
   localparam logic [DW-1:0] LAST_DRN = DW'((DRAIN > 0) ? DRAIN - 1 : 0);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DRAIN, ST_REPORT} state_t;

   state_t          state, state_next;
   logic [FLEN-1:0] shreg, shreg_next;
   logic [BW-1:0]   bit_cnt, bit_cnt_next;
   logic [DW-1:0]   drn_cnt, drn_cnt_next;
   logic [HW-1:0]   cnt, cnt_next, cnt_inc;
   logic [IW-1:0]   win, win_next, sel;
   logic [NREQ-1:0] gnt_next, sel_oh;
   logic            line_next, done_next, busy_next, finish;
   logic [3:0]      done_id_next;
   logic [HW-1:0]   hits_next;
   logic [FLEN-1:0] frames [2**IW];

   // Pad the frame table to a power of two so the winner index is always in range.
   generate
      for (genvar gi = 0; gi < 2**IW; gi++) begin : g_frame
         if (gi < NREQ) begin : g_used
            assign frames[gi] = frame[gi*FLEN +: FLEN];
         end else begin : g_pad
            assign frames[gi] = '0;
         end
      end
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_oh
         assign sel_oh[gi] = (sel == IW'(gi));
      end
   endgenerate

   assign cnt_inc = (U && (cnt != {HW{1'b1}})) ? cnt + 1'b1 : cnt;

`ifdef B02_LINE_ARB_RR_EN
   logic [IW-1:0] ptr, ptr_next;

   // Descending scan so the requester closest to ptr (in wrap order) wins.
   always_comb begin
      int idx;
      idx = 0;
      sel = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[idx]) sel = IW'(idx);
      end
   end
`else
   always_comb begin
      sel = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[k]) sel = IW'(k);
      end
   end
`endif

   always_comb begin
      state_next   = state;
      shreg_next   = shreg;
      bit_cnt_next = bit_cnt;
      drn_cnt_next = drn_cnt;
      cnt_next     = cnt;
      win_next     = win;
      gnt_next     = '0;
      line_next    = 1'b1;
      done_next    = 1'b0;
      done_id_next = done_id;
      hits_next    = hits;
      finish       = 1'b0;
`ifdef B02_LINE_ARB_RR_EN
      ptr_next     = ptr;
`endif
      case (state)
         ST_IDLE: begin
            if (|req) begin
               state_next   = ST_SHIFT;
               win_next     = sel;
               gnt_next     = sel_oh;
               line_next    = frames[sel][0];
               shreg_next   = frames[sel] >> 1;
               bit_cnt_next = '0;
               cnt_next     = '0;
            end
         end
         ST_SHIFT: begin
            cnt_next = cnt_inc;
            if (bit_cnt == LAST_BIT) begin
               drn_cnt_next = '0;
               if (DRAIN > 0) begin
                  state_next = ST_DRAIN;
               end else begin
                  state_next = ST_REPORT;
                  finish     = 1'b1;
               end
            end else begin
               line_next    = shreg[0];
               shreg_next   = shreg >> 1;
               bit_cnt_next = bit_cnt + 1'b1;
            end
         end
         ST_DRAIN: begin
            cnt_next = cnt_inc;
            if (drn_cnt == LAST_DRN) begin
               state_next = ST_REPORT;
               finish     = 1'b1;
            end else begin
               drn_cnt_next = drn_cnt + 1'b1;
            end
         end
         ST_REPORT: begin
            state_next = ST_IDLE;
`ifdef B02_LINE_ARB_RR_EN
            ptr_next = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
         end
         default: state_next = ST_IDLE;
      endcase
      // The last counted U lands on the same edge that enters REPORT.
      if (finish) begin
         done_next    = 1'b1;
         done_id_next = 4'(win);
         hits_next    = cnt_inc;
      end
      busy_next = (state_next != ST_IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         drn_cnt <= '0;
         cnt     <= '0;
         win     <= '0;
         gnt     <= '0;
         LINEA   <= 1'b1;
         done    <= 1'b0;
         done_id <= '0;
         hits    <= '0;
         busy    <= 1'b0;
`ifdef B02_LINE_ARB_RR_EN
         ptr     <= '0;
`endif
      end else begin
         state   <= state_next;
         shreg   <= shreg_next;
         bit_cnt <= bit_cnt_next;
         drn_cnt <= drn_cnt_next;
         cnt     <= cnt_next;
         win     <= win_next;
         gnt     <= gnt_next;
         LINEA   <= line_next;
         done    <= done_next;
         done_id <= done_id_next;
         hits    <= hits_next;
         busy    <= busy_next;
`ifdef B02_LINE_ARB_RR_EN
         ptr     <= ptr_next;
`endif
      end
   end
endmodule

// File: tb/tb_b02_line_arbiter.sv
// Testbench for b02_line_arbiter: directed and randomized frames against a behavioural model.
// The bench plays the requesters and the detector (drives U); a second instance with HW=2 covers saturation.
`timescale 1ns/1ps
module tb_b02_line_arbiter;
   localparam int NREQ  = 4;
   localparam int FLEN  = 8;
   localparam int DRAIN = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] frame = '0;
   logic        U = 1'b0;
   logic [3:0]  gnt, gnt2, done_id, id2, hits;
   logic [1:0]  hits2;
   logic        LINEA, line2, done, done2, busy, busy2;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_gnt = -1;
   int ptr = 0;

   always #5 clock = ~clock;

   b02_line_arbiter #(.NREQ(NREQ), .FLEN(FLEN), .DRAIN(DRAIN), .HW(4)) dut (
      .clock(clock), .reset_n(reset_n), .req(req), .frame(frame), .gnt(gnt), .LINEA(LINEA),
      .U(U), .done(done), .done_id(done_id), .hits(hits), .busy(busy));

   b02_line_arbiter #(.NREQ(NREQ), .FLEN(FLEN), .DRAIN(DRAIN), .HW(2)) dut2 (
      .clock(clock), .reset_n(reset_n), .req(req), .frame(frame), .gnt(gnt2), .LINEA(line2),
      .U(U), .done(done2), .done_id(id2), .hits(hits2), .busy(busy2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
`ifdef B02_LINE_ARB_RR_EN
         if (r[(p + k) % 4]) return (p + k) % 4;
`else
         if (r[k]) return k + 0 * p;
`endif
      end
      return 0;
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // One transaction: capture edge, FLEN+DRAIN counted cycles, REPORT, then one IDLE cycle.
   task automatic do_frame(input logic [3:0] newreq, input logic [9:0] upat, input bit keep,
                           input bit pulse2, input logic [3:0] latereq, input int abort_k);
      int w;
      int cnt;
      logic [7:0] ef;
      logic [3:0] oh;
      req = req | newreq;
      w   = pick(req, ptr);
      ef  = frame[w*8 +: 8];
      oh  = 4'b0001 << w;
      tick();
      chk("gnt", gnt, oh);
      chk("gnt_hw2", gnt2, oh);
      chk("busy_first", busy, 1);
      chk("line_bit0", LINEA, ef[0]);
      if (last_gnt >= 0) chk("gnt_spacing", cyc - last_gnt, 12);
      last_gnt = cyc;
      if (!keep) req[w] = 1'b0;
      frame[w*8 +: 8] = 8'($urandom);
      cnt = 0;
      for (int k = 0; k < FLEN + DRAIN; k++) begin
         if (k == abort_k) begin
            #2 reset_n = 1'b0;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_gnt", gnt, 0);
            chk("rst_done", done, 0);
            chk("rst_line", LINEA, 1);
            chk("rst_hits", hits, 0);
            chk("rst_id", done_id, 0);
            ptr = 0;
            last_gnt = -1;
            tick();
            chk("rst_hold_busy", busy, 0);
            chk("rst_hold_done", done, 0);
            #3 reset_n = 1'b1;
            $display("[TB] frame id=%0d data=%02h aborted by reset at shift cycle %0d", w, ef, k);
            return;
         end
         if (k > 0) begin
            chk("line", LINEA, (k < FLEN) ? ef[k] : 1'b1);
            chk("gnt_low", gnt, 0);
            chk("busy", busy, 1);
            chk("done_low", done, 0);
         end
         if (pulse2 && k == 3) req[2] = 1'b1;
         if (pulse2 && k == 4) req[2] = 1'b0;
         U = upat[k];
         cnt += int'(upat[k]);
         tick();
      end
      chk("done", done, 1);
      chk("done_hw2", done2, 1);
      chk("done_id", done_id, w);
      chk("hits", hits, sat(cnt, 15));
      chk("hits_hw2", hits2, sat(cnt, 3));
      chk("busy_report", busy, 1);
      chk("line_report", LINEA, 1);
      req = req | latereq;
      U = 1'($urandom);
`ifdef B02_LINE_ARB_RR_EN
      ptr = (w + 1) % 4;
`endif
      tick();
      chk("done_clear", done, 0);
      chk("busy_idle", busy, 0);
      chk("busy_idle_hw2", busy2, 0);
      chk("line_idle", LINEA, 1);
      chk("line_idle_hw2", line2, 1);
      chk("hits_hold", hits, sat(cnt, 15));
      chk("id_hold", done_id, w);
      chk("id_hold_hw2", id2, w);
      U = 1'($urandom);
      $display("[TB] frame id=%0d data=%02h u=%03h hits=%0d", w, ef, upat, sat(cnt, 15));
   endtask

   initial begin
      logic [3:0] nr;
      frame = $urandom;
      #1 reset_n = 1'b0;
      #2;
      chk("reset_busy", busy, 0);
      chk("reset_gnt", gnt, 0);
      chk("reset_done", done, 0);
      chk("reset_line", LINEA, 1);
      chk("reset_id", done_id, 0);
      chk("reset_hits", hits, 0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk("idle_no_req_busy", busy, 0);
      chk("idle_no_req_gnt", gnt, 0);

      // Constant request pattern 1011: round robin order 0,1,3,0,1; fixed priority always 0.
      for (int i = 0; i < 5; i++) do_frame(4'b1011, 10'($urandom), 1'b1, 1'b0, 4'b0, -1);
      req = '0;
      tick();
      last_gnt = -1;

      // Serialization of A5 with U in shift cycles 2 and 5 and drain cycle 1.
      frame[7:0] = 8'hA5;
      do_frame(4'b0001, 10'h224, 1'b0, 1'b0, 4'b0, -1);
      // U held high for the whole window.
      do_frame(4'b0001, 10'h3FF, 1'b0, 1'b0, 4'b0, -1);

      // req[2] pulsed for one cycle while busy must not be granted.
      do_frame(4'b0001, 10'($urandom), 1'b0, 1'b1, 4'b0, -1);
      tick();
      chk("withdraw_gnt", gnt, 0);
      chk("withdraw_busy", busy, 0);
      tick();
      chk("withdraw_gnt2", gnt, 0);
      last_gnt = -1;
      // 0110 raised during REPORT is seen by the following IDLE edge.
      do_frame(4'b0001, 10'($urandom), 1'b0, 1'b0, 4'b0110, -1);
      do_frame(4'b0000, 10'($urandom), 1'b0, 1'b0, 4'b0, -1);
      do_frame(4'b0000, 10'($urandom), 1'b0, 1'b0, 4'b0, -1);

      for (int i = 0; i < 20; i++) begin
         nr = 4'($urandom_range(0, 15));
         if ((req | nr) == 4'b0) nr = 4'b0001 << $urandom_range(0, 3);
         do_frame(nr, 10'($urandom), 1'($urandom), 1'b0, 4'b0, -1);
      end

      // Reset in shift cycle 4 with req 0001 held; regranted right after release.
      req = '0;
      do_frame(4'b0001, 10'($urandom), 1'b1, 1'b0, 4'b0, 4);
      do_frame(4'b0000, 10'($urandom), 1'b0, 1'b0, 4'b0, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
